// File: rtl/uidbuf_pkg.sv
// Shared definitions for the read-side FDMA address engine: FSM encoding
// and the elaboration-time burst geometry helpers.
package uidbuf_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RST   = 3'd1;
  localparam logic [2:0] S_REQ   = 3'd2;
  localparam logic [2:0] S_WBUSY = 3'd3;
  localparam logic [2:0] S_WDONE = 3'd4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int burst_len(input int xsize, input int dw, input int axi_dw, input int xdiv);
    return xsize * dw / axi_dw / xdiv;
  endfunction

  function automatic int inc_bytes(input int xsize, input int dw, input int xdiv);
    return xsize * (dw / 8) / xdiv;
  endfunction

  // Last burst of a line also skips the stride padding to reach the next line start.
  function automatic int last_inc_bytes(input int xsize, input int xstride, input int dw, input int xdiv);
    return (xstride - xsize) * (dw / 8) + inc_bytes(xsize, dw, xdiv);
  endfunction

endpackage

// File: rtl/uidbuf_ch_base_rom.sv
// Constant per-channel base address mux; every entry is folded at elaboration.
module uidbuf_ch_base_rom #(
  parameter int     AW        = 32,
  parameter int     NUM_CH    = 4,
  parameter int     CH_W      = 2,
  parameter longint BASE_ADDR = 0,
  parameter longint CH_STRIDE = 0
) (
  input  logic [CH_W-1:0] ch,
  output logic [AW-1:0]   base
);

  always_comb begin
    base = AW'(BASE_ADDR);
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch == CH_W'(i)) base = AW'(BASE_ADDR + longint'(i) * CH_STRIDE);
    end
  end

endmodule

// File: rtl/uidbuf_r_mch_addr_gen.sv
// Read-side FDMA request engine: picks a source channel per frame, resets the
// downstream FIFO, then walks YSIZE*XDIV bursts throttled on FIFO fill level.
module uidbuf_r_mch_addr_gen
  import uidbuf_pkg::*;
#(
  parameter int     AXI_DATA_WIDTH = 128,
  parameter int     AXI_ADDR_WIDTH = 32,
  parameter int     DATAWIDTH      = 32,
  parameter int     DSIZEBITS      = 24,
  parameter int     XSIZE          = 1920,
  parameter int     XSTRIDE        = 1920,
  parameter int     YSIZE          = 1080,
  parameter int     XDIV           = 2,
  parameter int     NUM_CH         = 4,
  parameter longint BASE_ADDR      = 1843200,
  parameter longint CH_STRIDE      = 1843200,
  parameter int     FIFO_DEPTH     = 512,
  parameter int     WCNT_W         = 10,
  parameter int     RST_HI         = 40,
  parameter int     RST_TOTAL      = 100,
  parameter int     IRQ_CYCLES     = 60,
  localparam int    CH_W           = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
  input  logic                      I_ui_clk,
  input  logic                      I_ui_rstn,
  input  logic                      I_fs,
  input  logic [CH_W-1:0]           I_ch_sel,
  input  logic [7:0]                I_buf_idx,
  input  logic [WCNT_W-1:0]         I_fifo_wcnt,
  input  logic                      I_fdma_rbusy,
  output logic [AXI_ADDR_WIDTH-1:0] O_fdma_raddr,
  output logic                      O_fdma_rareq,
  output logic [15:0]               O_fdma_rsize,
  output logic                      O_fifo_rst,
  output logic [CH_W-1:0]           O_cur_ch,
  output logic [7:0]                O_rbuf,
  output logic                      O_irq,
  output logic                      O_fs_miss,
  output logic                      O_sel_err
);

  localparam int BURST    = burst_len(XSIZE, DATAWIDTH, AXI_DATA_WIDTH, XDIV);
  localparam int INC      = inc_bytes(XSIZE, DATAWIDTH, XDIV);
  localparam int LAST_INC = last_inc_bytes(XSIZE, XSTRIDE, DATAWIDTH, XDIV);
  localparam int TIMES    = YSIZE * XDIV;
  localparam int BCNT_W   = clog2(TIMES + 1);
  localparam int RST_W    = clog2(RST_TOTAL + 1);
  localparam int IRQ_W    = clog2(IRQ_CYCLES + 1);

  logic [2:0]           state_q, state_d;
  logic [DSIZEBITS-1:0] r_addr_q, r_addr_d;
  logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
  logic [3:0]           div_cnt_q, div_cnt_d;
  logic [RST_W-1:0]     rst_cnt_q, rst_cnt_d;
  logic [IRQ_W-1:0]     irq_cnt_q, irq_cnt_d;
  logic [7:0]           bufn_q, bufn_d;
  logic [7:0]           rbuf_q, rbuf_d;
  logic [CH_W-1:0]      cur_ch_q, cur_ch_d;
  logic                 rareq_q, rareq_d;
  logic                 fifo_rst_q, fifo_rst_d;
  logic                 fs_miss_q, fs_miss_d;
  logic                 sel_err_q, sel_err_d;
  logic [AXI_ADDR_WIDTH-1:0] ch_base;

  uidbuf_ch_base_rom #(
    .AW        (AXI_ADDR_WIDTH),
    .NUM_CH    (NUM_CH),
    .CH_W      (CH_W),
    .BASE_ADDR (BASE_ADDR),
    .CH_STRIDE (CH_STRIDE)
  ) u_base_rom (
    .ch   (cur_ch_q),
    .base (ch_base)
  );

  always_comb begin
    state_d    = state_q;
    r_addr_d   = r_addr_q;
    bcnt_d     = bcnt_q;
    div_cnt_d  = div_cnt_q;
    rst_cnt_d  = rst_cnt_q;
    bufn_d     = bufn_q;
    rbuf_d     = rbuf_q;
    cur_ch_d   = cur_ch_q;
    rareq_d    = rareq_q;
    sel_err_d  = sel_err_q;
    fs_miss_d  = I_fs && (state_q != S_IDLE);
    irq_cnt_d  = (irq_cnt_q != '0) ? irq_cnt_q - IRQ_W'(1) : '0;

    case (state_q)
      S_IDLE: begin
        r_addr_d  = '0;
        bcnt_d    = '0;
        div_cnt_d = '0;
        rst_cnt_d = '0;
        if (I_fs) begin
          if (int'(I_ch_sel) < NUM_CH) cur_ch_d = I_ch_sel;
          else                         sel_err_d = 1'b1;
          state_d = S_RST;
        end
      end
      S_RST: begin
        bufn_d = I_buf_idx;
        if (int'(rst_cnt_q) < RST_TOTAL - 1) rst_cnt_d = rst_cnt_q + RST_W'(1);
        // A previous frame's irq must finish before the next frame starts fetching.
        if (int'(rst_cnt_q) >= RST_TOTAL - 1 && irq_cnt_q == '0) state_d = S_REQ;
      end
      S_REQ: begin
        if (!I_fdma_rbusy && int'(I_fifo_wcnt) < FIFO_DEPTH - BURST) begin
          rareq_d = 1'b1;
          state_d = S_WBUSY;
        end
      end
      S_WBUSY: begin
        if (I_fdma_rbusy) begin
          rareq_d = 1'b0;
          state_d = S_WDONE;
        end
      end
      S_WDONE: begin
        if (!I_fdma_rbusy) begin
          if (int'(bcnt_q) == TIMES - 1) begin
            state_d   = S_IDLE;
            irq_cnt_d = IRQ_W'(IRQ_CYCLES);
            rbuf_d    = bufn_q;
          end else begin
            if (int'(div_cnt_q) < XDIV - 1) begin
              r_addr_d  = r_addr_q + DSIZEBITS'(INC);
              div_cnt_d = div_cnt_q + 4'd1;
            end else begin
              r_addr_d  = r_addr_q + DSIZEBITS'(LAST_INC);
              div_cnt_d = '0;
            end
            bcnt_d  = bcnt_q + BCNT_W'(1);
            state_d = S_REQ;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        rareq_d = 1'b0;
      end
    endcase

    fifo_rst_d = (state_d == S_RST) && (int'(rst_cnt_d) < RST_HI);
  end

  always_ff @(posedge I_ui_clk or negedge I_ui_rstn) begin
    if (!I_ui_rstn) begin
      state_q    <= S_IDLE;
      r_addr_q   <= '0;
      bcnt_q     <= '0;
      div_cnt_q  <= '0;
      rst_cnt_q  <= '0;
      irq_cnt_q  <= '0;
      bufn_q     <= '0;
      rbuf_q     <= '0;
      cur_ch_q   <= '0;
      rareq_q    <= 1'b0;
      fifo_rst_q <= 1'b0;
      fs_miss_q  <= 1'b0;
      sel_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_addr_q   <= r_addr_d;
      bcnt_q     <= bcnt_d;
      div_cnt_q  <= div_cnt_d;
      rst_cnt_q  <= rst_cnt_d;
      irq_cnt_q  <= irq_cnt_d;
      bufn_q     <= bufn_d;
      rbuf_q     <= rbuf_d;
      cur_ch_q   <= cur_ch_d;
      rareq_q    <= rareq_d;
      fifo_rst_q <= fifo_rst_d;
      fs_miss_q  <= fs_miss_d;
      sel_err_q  <= sel_err_d;
    end
  end

  assign O_fdma_raddr = ch_base + AXI_ADDR_WIDTH'({bufn_q, r_addr_q});
  assign O_fdma_rareq = rareq_q;
  assign O_fdma_rsize = 16'(BURST);
  assign O_fifo_rst   = fifo_rst_q;
  assign O_cur_ch     = cur_ch_q;
  assign O_rbuf       = rbuf_q;
  assign O_irq        = (irq_cnt_q != '0);
  assign O_fs_miss    = fs_miss_q;
  assign O_sel_err    = sel_err_q;

endmodule

// File: tb/tb_uidbuf_r_mch_addr_gen.sv
// Self-checking bench: table-driven frames, throttle/miss/reset sequences and
// randomized frames against an arithmetic address model.
module tb_uidbuf_r_mch_addr_gen;

  localparam int     XSIZE = 16, XSTRIDE = 32, YSIZE = 2, XDIV = 2, DW = 32, AXI_DW = 128;
  localparam int     DSB = 8, NCH = 4, RST_HI = 4, RST_TOTAL = 8, IRQ_CYC = 6;
  localparam int     FIFO_DEPTH = 16, WCNT_W = 5;
  localparam longint BASE = 64'h1000, CH_STR = 64'h1000;
  localparam int     NBURSTS = YSIZE * XDIV;

  logic clk = 1'b0, rst_n = 1'b0, fs = 1'b0, rbusy = 1'b0;
  logic [1:0] ch_sel = '0;
  logic [7:0] buf_idx = '0;
  logic [WCNT_W-1:0] wcnt = '0;
  logic [31:0] raddr;
  logic rareq, fifo_rst, irq, fs_miss, sel_err;
  logic [15:0] rsize;
  logic [1:0] cur_ch;
  logic [7:0] rbuf;

  logic fs2 = 1'b0;
  logic [1:0] ch_sel2 = '0;
  logic [31:0] raddr2;
  logic rareq2, fifo_rst2, irq2, fs_miss2, sel_err2;
  logic [15:0] rsize2;
  logic [1:0] cur_ch2;
  logic [7:0] rbuf2;

  int checks = 0, errors = 0;
  int cyc = 0, fs_cyc = 0, first_req_cyc = 0;
  int irq_cyc = 0, fifo_rst_cyc = 0, miss_cnt = 0;
  bit rand_mode = 0;
  logic rareq_prev = 1'b0;
  logic [31:0] cap_q[$];
  logic [15:0] cap_size_q[$];

  typedef struct packed {
    logic [1:0]       ch;
    logic [7:0]       bufi;
    logic [3:0][31:0] exp_addr;
  } vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uidbuf_r_mch_addr_gen #(
    .AXI_DATA_WIDTH(AXI_DW), .AXI_ADDR_WIDTH(32), .DATAWIDTH(DW), .DSIZEBITS(DSB),
    .XSIZE(XSIZE), .XSTRIDE(XSTRIDE), .YSIZE(YSIZE), .XDIV(XDIV), .NUM_CH(NCH),
    .BASE_ADDR(BASE), .CH_STRIDE(CH_STR), .FIFO_DEPTH(FIFO_DEPTH), .WCNT_W(WCNT_W),
    .RST_HI(RST_HI), .RST_TOTAL(RST_TOTAL), .IRQ_CYCLES(IRQ_CYC)
  ) dut (
    .I_ui_clk(clk), .I_ui_rstn(rst_n), .I_fs(fs), .I_ch_sel(ch_sel), .I_buf_idx(buf_idx),
    .I_fifo_wcnt(wcnt), .I_fdma_rbusy(rbusy), .O_fdma_raddr(raddr), .O_fdma_rareq(rareq),
    .O_fdma_rsize(rsize), .O_fifo_rst(fifo_rst), .O_cur_ch(cur_ch), .O_rbuf(rbuf),
    .O_irq(irq), .O_fs_miss(fs_miss), .O_sel_err(sel_err)
  );

  // Second instance with three channels so an out-of-range select fits in CH_W bits.
  uidbuf_r_mch_addr_gen #(
    .AXI_DATA_WIDTH(AXI_DW), .AXI_ADDR_WIDTH(32), .DATAWIDTH(DW), .DSIZEBITS(DSB),
    .XSIZE(XSIZE), .XSTRIDE(XSTRIDE), .YSIZE(YSIZE), .XDIV(XDIV), .NUM_CH(3),
    .BASE_ADDR(BASE), .CH_STRIDE(CH_STR), .FIFO_DEPTH(FIFO_DEPTH), .WCNT_W(WCNT_W),
    .RST_HI(RST_HI), .RST_TOTAL(RST_TOTAL), .IRQ_CYCLES(IRQ_CYC)
  ) dut3 (
    .I_ui_clk(clk), .I_ui_rstn(rst_n), .I_fs(fs2), .I_ch_sel(ch_sel2), .I_buf_idx(8'd0),
    .I_fifo_wcnt(5'd0), .I_fdma_rbusy(rareq2), .O_fdma_raddr(raddr2), .O_fdma_rareq(rareq2),
    .O_fdma_rsize(rsize2), .O_fifo_rst(fifo_rst2), .O_cur_ch(cur_ch2), .O_rbuf(rbuf2),
    .O_irq(irq2), .O_fs_miss(fs_miss2), .O_sel_err(sel_err2)
  );

  // FDMA model: each accepted request keeps rbusy high for a fixed or random span.
  initial begin : fdma_model
    int busy_left;
    busy_left = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) busy_left = 0;
      else if (busy_left > 0) busy_left--;
      else if (rareq) busy_left = rand_mode ? int'($urandom_range(1, 4)) : 3;
      rbusy = (busy_left > 0);
    end
  end

  initial begin : wcnt_noise
    forever begin
      @(posedge clk);
      #2;
      if (rand_mode) wcnt = WCNT_W'($urandom_range(0, 15));
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (rareq && !rareq_prev) begin
        if (cap_q.size() == 0) first_req_cyc = cyc;
        cap_q.push_back(raddr);
        cap_size_q.push_back(rsize);
      end
      if (fifo_rst) fifo_rst_cyc++;
      if (irq) irq_cyc++;
      if (fs_miss) miss_cnt++;
    end
    rareq_prev = rareq;
  end

  // Byte address of burst k: line start plus burst slot within the line.
  function automatic logic [31:0] ref_addr(input int ch, input int b, input int k);
    longint a;
    a = BASE + longint'(ch) * CH_STR + longint'(b) * (64'd1 << DSB)
        + longint'((k / XDIV) * XSTRIDE * (DW / 8))
        + longint'((k % XDIV) * (XSIZE * (DW / 8) / XDIV));
    return a[31:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] ch, input logic [7:0] b, input bit clear);
    @(posedge clk);
    #1;
    if (clear) begin
      cap_q.delete();
      cap_size_q.delete();
      irq_cyc = 0;
      fifo_rst_cyc = 0;
      miss_cnt = 0;
    end
    ch_sel = ch;
    buf_idx = b;
    fs = 1'b1;
    @(posedge clk);
    #1;
    if (clear) fs_cyc = cyc;
    fs = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!irq && n < 400) begin @(negedge clk); n++; end
    checkOutput({tag, "_done"}, {31'd0, irq}, 32'd1);
    n = 0;
    while (irq && n < 40) begin @(negedge clk); n++; end
    @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int ch, input int b, input int exp_miss);
    logic [31:0] got;
    checkOutput({tag, "_nreq"}, cap_q.size(), NBURSTS);
    for (int i = 0; i < NBURSTS; i++) begin
      got = (i < cap_q.size()) ? cap_q[i] : 32'hDEAD_BEEF;
      checkOutput($sformatf("%s_addr%0d", tag, i), got, ref_addr(ch, b, i));
    end
    checkOutput({tag, "_rsize"}, (cap_size_q.size() > 0) ? 32'(cap_size_q[0]) : 32'd0, 32'd2);
    checkOutput({tag, "_rbuf"}, rbuf, b);
    checkOutput({tag, "_cur_ch"}, cur_ch, ch);
    checkOutput({tag, "_irq_len"}, irq_cyc, IRQ_CYC);
    checkOutput({tag, "_fs_miss"}, miss_cnt, exp_miss);
  endtask

  task automatic set_vec(input int i, input logic [1:0] ch, input logic [7:0] b,
                         input logic [31:0] a0, a1, a2, a3);
    vecs[i].ch = ch;
    vecs[i].bufi = b;
    vecs[i].exp_addr[0] = a0;
    vecs[i].exp_addr[1] = a1;
    vecs[i].exp_addr[2] = a2;
    vecs[i].exp_addr[3] = a3;
  endtask

  initial begin : main
    int n;
    logic [1:0] rch;
    logic [7:0] rb;

    set_vec(0, 2'd1, 8'h01, 32'h2100, 32'h2120, 32'h2180, 32'h21A0);
    set_vec(1, 2'd3, 8'h02, 32'h4200, 32'h4220, 32'h4280, 32'h42A0);
    set_vec(2, 2'd0, 8'hFF, 32'h10F00, 32'h10F20, 32'h10F80, 32'h10FA0);
    set_vec(3, 2'd2, 8'h10, 32'h4000, 32'h4020, 32'h4080, 32'h40A0);

    repeat (3) @(negedge clk);
    checkOutput("rst_rareq", rareq, 0);
    checkOutput("rst_fifo_rst", fifo_rst, 0);
    checkOutput("rst_cur_ch", cur_ch, 0);
    checkOutput("rst_rbuf", rbuf, 0);
    checkOutput("rst_irq", irq, 0);
    checkOutput("rst_fs_miss", fs_miss, 0);
    checkOutput("rst_sel_err", sel_err, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      applyStimulus(vecs[v].ch, vecs[v].bufi, 1'b1);
      wait_done($sformatf("vec%0d", v));
      checkOutput($sformatf("vec%0d_nreq", v), cap_q.size(), 4);
      for (int i = 0; i < 4; i++)
        checkOutput($sformatf("vec%0d_addr%0d", v, i),
                    (i < cap_q.size()) ? cap_q[i] : 32'hDEAD_BEEF, vecs[v].exp_addr[i]);
      checkOutput($sformatf("vec%0d_rsize", v),
                  (cap_size_q.size() > 0) ? 32'(cap_size_q[0]) : 32'd0, 32'd2);
      checkOutput($sformatf("vec%0d_rbuf", v), rbuf, vecs[v].bufi);
      checkOutput($sformatf("vec%0d_cur_ch", v), cur_ch, vecs[v].ch);
      checkOutput($sformatf("vec%0d_irq_len", v), irq_cyc, 6);
      checkOutput($sformatf("vec%0d_fifo_rst_len", v), fifo_rst_cyc, 4);
      checkOutput($sformatf("vec%0d_req_latency_ge8", v), {31'd0, (first_req_cyc - fs_cyc) >= 8}, 1);
    end

    // FIFO throttle boundary: rareq needs wcnt strictly below FIFO_DEPTH-BURST.
    wcnt = 5'd15;
    applyStimulus(2'd1, 8'h01, 1'b1);
    repeat (30) @(negedge clk);
    checkOutput("throttle_15_noreq", cap_q.size(), 0);
    wcnt = 5'd14;
    repeat (5) @(negedge clk);
    checkOutput("throttle_14_noreq", cap_q.size(), 0);
    wcnt = 5'd13;
    @(negedge clk);
    checkOutput("throttle_13_req_next", rareq, 1);
    wcnt = 5'd0;
    wait_done("throttle");
    check_frame("throttle", 1, 1, 0);

    // Frame-start arriving mid-frame is reported and otherwise ignored.
    applyStimulus(2'd1, 8'h01, 1'b1);
    n = 0;
    while (cap_q.size() < 2 && n < 200) begin @(negedge clk); n++; end
    checkOutput("miss_two_bursts_seen", cap_q.size(), 2);
    applyStimulus(2'd3, 8'h01, 1'b0);
    wait_done("miss");
    check_frame("miss", 1, 1, 1);
    applyStimulus(2'd3, 8'h00, 1'b1);
    wait_done("after_miss");
    check_frame("after_miss", 3, 0, 0);
    checkOutput("after_miss_first", (cap_q.size() > 0) ? cap_q[0] : 32'h0, 32'h4000);

    // Out-of-range channel select on the three-channel instance.
    @(negedge clk); ch_sel2 = 2'd2; fs2 = 1'b1;
    @(negedge clk); fs2 = 1'b0;
    n = 0;
    while (!irq2 && n < 400) begin @(negedge clk); n++; end
    checkOutput("sel_valid_cur_ch", cur_ch2, 2);
    checkOutput("sel_valid_no_err", sel_err2, 0);
    repeat (8) @(negedge clk);
    ch_sel2 = 2'd3; fs2 = 1'b1;
    @(negedge clk); fs2 = 1'b0;
    checkOutput("sel_bad_err", sel_err2, 1);
    checkOutput("sel_bad_cur_ch_held", cur_ch2, 2);
    n = 0;
    while (!irq2 && n < 400) begin @(negedge clk); n++; end
    checkOutput("sel_bad_frame_done", irq2, 1);
    checkOutput("sel_err_sticky", sel_err2, 1);
    checkOutput("main_sel_err_clear", sel_err, 0);

    // Reset while waiting on the FDMA abandons the frame at once.
    applyStimulus(2'd1, 8'h05, 1'b1);
    n = 0;
    while (!rareq && n < 200) begin @(negedge clk); n++; end
    checkOutput("rstmid_in_wbusy", rareq, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid_rareq", rareq, 0);
    checkOutput("rstmid_irq", irq, 0);
    checkOutput("rstmid_sel_err", sel_err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("rstmid_no_irq", irq_cyc, 0);
    applyStimulus(2'd2, 8'h03, 1'b1);
    wait_done("rstmid_next");
    check_frame("rstmid_next", 2, 3, 0);

    // Randomized frames with random FDMA latency and FIFO fill noise.
    rand_mode = 1;
    for (int k = 0; k < 8; k++) begin
      rch = 2'($urandom_range(0, 3));
      rb = 8'($urandom_range(0, 255));
      applyStimulus(rch, rb, 1'b1);
      wait_done($sformatf("rand%0d", k));
      check_frame($sformatf("rand%0d", k), int'(rch), int'(rb), 0);
    end
    rand_mode = 0;
    wcnt = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
